// File: rtl/multfrac_mac_pkg.sv
// Shared constants and types for the fractional multiplier / MAC block.
// The defaults give a 24-bit Q1.23 datapath with four multiplexed channels.
package multfrac_mac_pkg;
   localparam int DEF_W     = 24;
   localparam int DEF_NCH   = 4;
   localparam int DEF_PIPE  = 3;
   localparam int DEF_GUARD = 4;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_MAC = 1'b1
   } mode_e;

   // The sideband tag carried beside the multiplier is {ch, mode, acc_clr}.
   function automatic int tag_width(input int nch);
      return $clog2(nch) + 2;
   endfunction
endpackage

// File: rtl/multfrac_mac_if.sv
// Sample/result bus of multfrac_mac.
// The master drives operands and tags; the slave returns results.
interface multfrac_mac_if
   import multfrac_mac_pkg::*;
#(
   parameter int W   = DEF_W,
   parameter int NCH = DEF_NCH
);
   localparam int CW = $clog2(NCH);

   logic                 en;
   logic                 in_valid;
   logic [CW-1:0]        in_ch;
   logic                 mode;
   logic                 acc_clr;
   logic signed [W-1:0]  a;
   logic signed [W-1:0]  b;
   logic                 out_valid;
   logic [CW-1:0]        out_ch;
   logic signed [W-1:0]  out;
   logic                 sat;

   modport master (
      output en, in_valid, in_ch, mode, acc_clr, a, b,
      input  out_valid, out_ch, out, sat
   );

   modport slave (
      input  en, in_valid, in_ch, mode, acc_clr, a, b,
      output out_valid, out_ch, out, sat
   );
endinterface

// File: rtl/multfrac_mac_mult_pipe.sv
// Signed W x W -> 2W multiplier with PIPE registers and a clock enable.
// A valid bit and a sideband tag travel alongside at the same depth.
module multfrac_mac_mult_pipe
   import multfrac_mac_pkg::*;
#(
   parameter int W    = DEF_W,
   parameter int PIPE = DEF_PIPE,
   parameter int TW   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_ce,
   input  logic                  i_valid,
   input  logic [TW-1:0]         i_tag,
   input  logic signed [W-1:0]   i_a,
   input  logic signed [W-1:0]   i_b,
   output logic                  o_valid,
   output logic [TW-1:0]         o_tag,
   output logic signed [2*W-1:0] o_p
);
   logic signed [2*W-1:0] w_a_x;
   logic signed [2*W-1:0] w_b_x;
   logic signed [2*W-1:0] w_prod;
   logic signed [2*W-1:0] r_p   [PIPE];
   logic [TW-1:0]         r_tag [PIPE];
   logic [PIPE-1:0]       r_vld;

   // Full-width operands make the truncated product exact for any sign mix.
   assign w_a_x  = {{W{i_a[W-1]}}, i_a};
   assign w_b_x  = {{W{i_b[W-1]}}, i_b};
   assign w_prod = w_a_x * w_b_x;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vld <= '0;
      end else if (i_ce) begin
         r_vld[0] <= i_valid;
         for (int i = 1; i < PIPE; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_ce) begin
         r_p[0]   <= w_prod;
         r_tag[0] <= i_tag;
         for (int i = 1; i < PIPE; i++) begin
            r_p[i]   <= r_p[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign o_valid = r_vld[PIPE-1];
   assign o_tag   = r_tag[PIPE-1];
   assign o_p     = r_p[PIPE-1];
endmodule

// File: rtl/multfrac_mac.sv
// Time-multiplexed Q1.(W-1) multiplier with round-to-nearest, saturation and
// per-channel multiply-accumulate performed in the final pipeline stage.
module multfrac_mac
   import multfrac_mac_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int NCH   = DEF_NCH,
   parameter int PIPE  = DEF_PIPE,
   parameter int GUARD = DEF_GUARD
) (
   input logic           clk,
   input logic           reset,
   multfrac_mac_if.slave bus
);
   localparam int CW = $clog2(NCH);
   localparam int TW = tag_width(NCH);
   localparam int AW = W + GUARD;

   localparam logic signed [2*W-1:0] RND  = {{(W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
   localparam logic signed [W-1:0]   MAXW = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]   MINW = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [AW-1:0]  AMAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0]  AMIN = {1'b1, {(AW-1){1'b0}}};

   logic                  w_valid;
   logic [TW-1:0]         w_tag;
   logic signed [2*W-1:0] w_p;
   logic [CW-1:0]         w_ch;
   mode_e                 w_mode;
   logic                  w_clr;

   logic signed [2*W-1:0] w_psum;
   logic signed [W:0]     w_r;
   logic                  w_r_ovf;
   logic signed [W-1:0]   w_r_sat;
   logic signed [AW-1:0]  w_acc_base;
   logic signed [AW:0]    w_acc_sum;
   logic                  w_acc_ovf;
   logic signed [AW-1:0]  w_acc_next;
   logic [GUARD:0]        w_hi;
   logic                  w_out_ovf;
   logic signed [W-1:0]   w_acc_out;

   logic                  r_out_valid;
   logic [CW-1:0]         r_out_ch;
   logic signed [W-1:0]   r_out;
   logic                  r_sat;
   logic signed [AW-1:0]  r_acc [NCH];

   multfrac_mac_mult_pipe #(
      .W    (W),
      .PIPE (PIPE),
      .TW   (TW)
   ) u_mult (
      .clk     (clk),
      .reset   (reset),
      .i_ce    (bus.en),
      .i_valid (bus.in_valid),
      .i_tag   ({bus.in_ch, bus.mode, bus.acc_clr}),
      .i_a     (bus.a),
      .i_b     (bus.b),
      .o_valid (w_valid),
      .o_tag   (w_tag),
      .o_p     (w_p)
   );

   assign w_ch   = w_tag[TW-1:2];
   assign w_mode = mode_e'(w_tag[1]);
   assign w_clr  = w_tag[0];

   always_comb begin
      w_psum  = w_p + RND;
      w_r     = (W+1)'(w_psum >>> (W-1));
      w_r_ovf = w_r[W] ^ w_r[W-1];
      w_r_sat = w_r[W-1:0];
      if (w_r_ovf) begin
         w_r_sat = w_r[W] ? MINW : MAXW;
      end

      // Read-modify-write of the channel accumulator happens entirely here,
      // so back-to-back samples of one channel see the freshly written value.
      w_acc_base = w_clr ? '0 : r_acc[w_ch];
      w_acc_sum  = {w_acc_base[AW-1], w_acc_base} + {{(AW-W){w_r[W]}}, w_r};
      w_acc_ovf  = w_acc_sum[AW] ^ w_acc_sum[AW-1];
      w_acc_next = w_acc_sum[AW-1:0];
      if (w_acc_ovf) begin
         w_acc_next = w_acc_sum[AW] ? AMIN : AMAX;
      end

      w_hi      = w_acc_next[AW-1:W-1];
      w_out_ovf = !((&w_hi) || (~|w_hi));
      w_acc_out = w_acc_next[W-1:0];
      if (w_out_ovf) begin
         w_acc_out = w_acc_next[AW-1] ? MINW : MAXW;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out       <= '0;
         r_sat       <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            r_acc[i] <= '0;
         end
      end else if (bus.en) begin
         r_out_valid <= w_valid;
         if (w_valid) begin
            r_out_ch <= w_ch;
            if (w_mode == MODE_MAC) begin
               r_acc[w_ch] <= w_acc_next;
               r_out       <= w_acc_out;
               r_sat       <= w_acc_ovf | w_out_ovf;
            end else begin
               r_out <= w_r_sat;
               r_sat <= w_r_ovf;
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_ch    = r_out_ch;
   assign bus.out       = r_out;
   assign bus.sat       = r_sat;
endmodule

// File: tb/tb_multfrac_mac.sv
// Directed bench for multfrac_mac at W=24, NCH=4, PIPE=3, GUARD=4.
module tb_multfrac_mac;
   typedef struct packed {
      logic [1:0]  ch;
      logic [23:0] v;
      logic        s;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   res_t q[$];

   multfrac_mac_if #(.W(24), .NCH(4)) bus ();

   multfrac_mac #(.W(24), .NCH(4), .PIPE(3), .GUARD(4)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One clock; results produced by an enabled edge are logged.
   task automatic step();
      logic en_prev;
      en_prev = bus.en;
      @(posedge clk);
      #1;
      if (en_prev && bus.out_valid) begin
         q.push_back('{bus.out_ch, bus.out, bus.sat});
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] ch, input logic m, input logic clr,
                        input logic [23:0] a, input logic [23:0] b);
      bus.in_valid = v;
      bus.in_ch    = ch;
      bus.mode     = m;
      bus.acc_clr  = clr;
      bus.a        = a;
      bus.b        = b;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_one(input logic [1:0] ch, input logic m, input logic clr,
                          input logic [23:0] a, input logic [23:0] b, output int lat);
      drive(1'b1, ch, m, clr, a, b);
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic check_q(input string name, input res_t exp[8]);
      res_t got;
      chk({name, "_count"}, q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         got = (i < q.size()) ? q[i] : '1;
         chk($sformatf("%s[%0d]", name, i), 32'(got), 32'(exp[i]));
      end
   endtask

   task automatic stream5(input logic do_stall, input logic [23:0] bt[8], input res_t exp[8]);
      q.delete();
      for (int i = 0; i < 8; i++) begin
         if (do_stall && i == 4) begin
            bus.en = 1'b0;
            for (int k = 0; k < 5; k++) begin
               step();
               chk("t5_stall_out", bus.out, 24'h008000);
               chk("t5_stall_vld", bus.out_valid, 1);
               chk("t5_stall_ch", bus.out_ch, 0);
            end
            chk("t5_stall_log", q.size(), 1);
            bus.en = 1'b1;
         end
         drive(1'b1, 2'(i % 4), 1'b0, 1'b0, 24'h400000, bt[i]);
         step();
      end
      idle(8);
   endtask

   initial begin
      int   lat;
      res_t e4[8];
      res_t e5[8];
      logic [23:0] b5[8];

      drive(1'b0, 2'd0, 1'b0, 1'b0, 24'h0, 24'h0);
      bus.en = 1'b1;
      rst_n  = 1'b0;
      step();
      step();
      chk("rst_out", bus.out, 0);
      chk("rst_vld", bus.out_valid, 0);
      chk("rst_ch", bus.out_ch, 0);
      chk("rst_sat", bus.sat, 0);
      rst_n = 1'b1;
      idle(2);

      // 1: half times half, latency
      run_one(2'd3, 1'b0, 1'b0, 24'h400000, 24'h400000, lat);
      chk("t1_lat", lat, 4);
      chk("t1_out", bus.out, 24'h200000);
      chk("t1_sat", bus.sat, 0);
      chk("t1_ch", bus.out_ch, 3);
      idle(3);
      chk("t1_hold", bus.out, 24'h200000);

      // 2: (-1)*(-1) clips
      run_one(2'd0, 1'b0, 1'b1, 24'h800000, 24'h800000, lat);
      chk("t2_out", bus.out, 24'h7FFFFF);
      chk("t2_sat", bus.sat, 1);
      idle(3);

      // 3: rounding half toward +inf
      run_one(2'd1, 1'b0, 1'b0, 24'h000001, 24'h400000, lat);
      chk("t3a_out", bus.out, 24'h000001);
      idle(3);
      run_one(2'd1, 1'b0, 1'b0, 24'h000001, 24'hC00000, lat);
      chk("t3b_out", bus.out, 24'h000000);
      chk("t3b_sat", bus.sat, 0);
      idle(3);

      // 4: MAC on ch2 interleaved with ch1, no gaps
      e4[0] = '{2'd2, 24'h200000, 1'b0};
      e4[1] = '{2'd1, 24'h080000, 1'b0};
      e4[2] = '{2'd2, 24'h400000, 1'b0};
      e4[3] = '{2'd1, 24'h100000, 1'b0};
      e4[4] = '{2'd2, 24'h600000, 1'b0};
      e4[5] = '{2'd1, 24'h180000, 1'b0};
      e4[6] = '{2'd2, 24'h7FFFFF, 1'b1};
      e4[7] = '{2'd1, 24'h200000, 1'b0};
      q.delete();
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) drive(1'b1, 2'd2, 1'b1, i == 0, 24'h400000, 24'h400000);
         else            drive(1'b1, 2'd1, 1'b1, i == 1, 24'h200000, 24'h200000);
         step();
      end
      idle(8);
      check_q("t4", e4);

      // 5: stream with and without a 5-cycle stall
      b5 = '{24'h010000, 24'h020000, 24'h100000, 24'hF00000,
             24'h7FFFFF, 24'h800000, 24'h000003, 24'hFFFFFD};
      e5[0] = '{2'd0, 24'h008000, 1'b0};
      e5[1] = '{2'd1, 24'h010000, 1'b0};
      e5[2] = '{2'd2, 24'h080000, 1'b0};
      e5[3] = '{2'd3, 24'hF80000, 1'b0};
      e5[4] = '{2'd0, 24'h400000, 1'b0};
      e5[5] = '{2'd1, 24'hC00000, 1'b0};
      e5[6] = '{2'd2, 24'h000002, 1'b0};
      e5[7] = '{2'd3, 24'hFFFFFF, 1'b0};
      stream5(1'b0, b5, e5);
      check_q("t5_run", e5);
      stream5(1'b1, b5, e5);
      check_q("t5_stall", e5);

      // 6: reset with samples in flight clears pipe and accumulators
      run_one(2'd0, 1'b1, 1'b1, 24'h400000, 24'h400000, lat);
      chk("t6_pre", bus.out, 24'h200000);
      idle(3);
      q.delete();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'd0, 1'b1, 1'b0, 24'h400000, 24'h400000);
         step();
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t6_rst_out", bus.out, 0);
      idle(10);
      chk("t6_no_out", q.size(), 0);
      run_one(2'd0, 1'b1, 1'b0, 24'h400000, 24'h400000, lat);
      chk("t6_lat", lat, 4);
      chk("t6_out", bus.out, 24'h200000);
      chk("t6_sat", bus.sat, 0);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
